// File: rtl/timer_unit_if.sv
// Control/status bundle for timer_unit: host-side controls in, counter state and strobes out.
interface timer_unit_if #(
  parameter int unsigned COUNTER_SIZE = 32,
  parameter int unsigned PRESC_SIZE   = 8
);
  logic                    enable;
  logic                    start;
  logic                    stop;
  logic                    dir;
  logic                    period_mode;
  logic                    one_shot;
  logic                    load;
  logic [COUNTER_SIZE-1:0] load_value;
  logic [COUNTER_SIZE-1:0] period;
  logic [COUNTER_SIZE-1:0] match_value;
  logic [PRESC_SIZE-1:0]   prescale;

  logic [COUNTER_SIZE-1:0] count;
  logic                    running;
  logic                    match_pulse;
  logic                    overflow;
  logic                    pwm_out;

  modport master (
    output enable, start, stop, dir, period_mode, one_shot, load,
    output load_value, period, match_value, prescale,
    input  count, running, match_pulse, overflow, pwm_out
  );

  modport slave (
    input  enable, start, stop, dir, period_mode, one_shot, load,
    input  load_value, period, match_value, prescale,
    output count, running, match_pulse, overflow, pwm_out
  );
endinterface

// File: rtl/timer_unit.sv
// Prescaled up/down timer with period/one-shot modes, compare strobe and wrap strobe.
// Optional PWM output is built only when TIMER_UNIT_PWM_EN is defined.
module timer_unit #(
  parameter int unsigned COUNTER_SIZE = 32,
  parameter int unsigned PRESC_SIZE   = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  timer_unit_if.slave  bus
);

  localparam logic [COUNTER_SIZE-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PRESC_SIZE-1:0]   p_q, p_d;
  logic [COUNTER_SIZE-1:0] count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    match_q, match_d;

  logic [COUNTER_SIZE-1:0] top;
  logic [COUNTER_SIZE-1:0] step_val;
  logic                    is_run;
  logic                    tick;
  logic                    wrap_cond;
  logic                    wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      p_q        <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      match_q    <= match_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    match_d    = 1'b0;

    top    = bus.period_mode ? bus.period : ALL_ONES;
    is_run = (state_q == ST_RUN);
    tick   = bus.enable & is_run & (p_q == bus.prescale);

    // Up mode also wraps on natural carry-out when count sits above top.
    if (bus.dir) begin
      wrap_cond = (count_q == '0);
      step_val  = wrap_cond ? top : count_q - COUNTER_SIZE'(1);
    end else begin
      wrap_cond = (count_q == top) | (count_q == ALL_ONES);
      step_val  = (count_q == top) ? '0 : count_q + COUNTER_SIZE'(1);
    end
    wrap = tick & ~bus.load & wrap_cond;

    if (bus.load) begin
      count_d = bus.load_value;
    end else if (tick && !(wrap && bus.one_shot)) begin
      count_d = step_val;
    end

    // Prescaler freezes with enable low, clears whenever the counter is not allowed to run.
    if (bus.load) begin
      p_d = '0;
    end else if (!bus.enable) begin
      p_d = p_q;
    end else if (!is_run || tick) begin
      p_d = '0;
    end else begin
      p_d = p_q + PRESC_SIZE'(1);
    end

    if (bus.stop) begin
      state_d = ST_IDLE;
    end else if (bus.start && !is_run) begin
      state_d = ST_RUN;
    end else if (wrap && bus.one_shot) begin
      state_d = ST_DONE;
    end

    overflow_d = wrap;
    // A one-shot hold is not a fresh arrival at the compare value.
    match_d    = tick & ~bus.load & ~(wrap & bus.one_shot) &
                 (count_d == bus.match_value);
  end

  assign bus.count       = count_q;
  assign bus.running     = (state_q == ST_RUN);
  assign bus.match_pulse = match_q;
  assign bus.overflow    = overflow_q;

`ifdef TIMER_UNIT_PWM_EN
  logic pwm_q, pwm_d;

  // Evaluated on next-state values so pwm_out lines up with the count it describes.
  always_comb begin
    pwm_d = (state_d == ST_RUN) &
            (bus.dir ? (count_d > bus.match_value) : (count_d < bus.match_value));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign bus.pwm_out = pwm_q;
`else
  assign bus.pwm_out = 1'b0;
`endif

endmodule
